// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue stage.
// State encoding, result flags and the divide-by-zero quotient pattern.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic dbz;
        logic err;
    } res_flags_t;

    // Wide enough for any supported N; users slice the low N bits.
    localparam logic [63:0] DBZ_QUOT = '1;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO holding {x, y} operand pairs for the divider issue stage.
// Full/empty derive from the registered count, so a pop never frees a slot for the same-cycle push.
module div_req_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [2*N-1:0]             wdata_i,
    input  logic                       pop_i,
    output logic [2*N-1:0]             rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [2*N-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/div_dispatch.sv
// Issue stage for restoring_divider: queues requests, launches one at a time, returns results in order.
// Divide-by-zero is answered locally; a divider that never completes yields an error response.
module div_dispatch
    import div_pkg::*;
#(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_x,
    input  logic [N-1:0] req_y,
    output logic         div_start,
    output logic [N-1:0] div_x,
    output logic [N-1:0] div_y,
    input  logic [N-1:0] div_quot,
    input  logic [N-1:0] div_rem,
    input  logic         div_valid,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_quot,
    output logic [N-1:0] res_rem,
    output logic         res_dbz,
    output logic         res_err,
    output logic         busy
);

    localparam int          TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2*N-1:0]          fifo_rdata;
    logic                    fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [N-1:0]            head_x, head_y;

    state_e        state_q, state_d;
    logic [N-1:0]  op_x_q, op_x_d, op_y_q, op_y_d;
    logic [N-1:0]  quot_q, quot_d, rem_q, rem_d;
    res_flags_t    flags_q, flags_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          dv_prev_q, dv_prev_d;

    div_req_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_valid),
        .wdata_i ({req_x, req_y}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_x   = fifo_rdata[2*N-1:N];
    assign head_y   = fifo_rdata[N-1:0];
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    // NOTE: every next-state signal defaults to its current value first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        op_x_d    = op_x_q;
        op_y_d    = op_y_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        flags_d   = flags_q;
        tmo_d     = tmo_q;
        dv_prev_d = dv_prev_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_y == '0) begin
                        quot_d  = DBZ_QUOT[N-1:0];
                        rem_d   = head_x;
                        flags_d = '{dbz: 1'b1, err: 1'b0};
                        state_d = ST_RESP;
                    end else begin
                        // Divider operands only change when a real launch follows.
                        op_x_d  = head_x;
                        op_y_d  = head_y;
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                tmo_d     = '0;
                dv_prev_d = 1'b0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                dv_prev_d = div_valid;
                if (div_valid && !dv_prev_q) begin
                    quot_d  = div_quot;
                    rem_d   = div_rem;
                    flags_d = '{dbz: 1'b0, err: 1'b0};
                    state_d = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    flags_d = '{dbz: 1'b0, err: 1'b1};
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_x_q    <= '0;
            op_y_q    <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            flags_q   <= '0;
            tmo_q     <= '0;
            dv_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_x_q    <= op_x_d;
            op_y_q    <= op_y_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            flags_q   <= flags_d;
            tmo_q     <= tmo_d;
            dv_prev_q <= dv_prev_d;
        end
    end

    assign req_ready = !fifo_full;
    assign div_start = (state_q == ST_LAUNCH);
    assign div_x     = op_x_q;
    assign div_y     = op_y_q;
    assign res_valid = (state_q == ST_RESP);
    assign res_quot  = quot_q;
    assign res_rem   = rem_q;
    assign res_dbz   = flags_q.dbz;
    assign res_err   = flags_q.err;
    assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_dispatch.sv
// Bench for div_dispatch: behavioural divider stub, arithmetic reference model and a result scoreboard.
// Stimulus drives 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_div_dispatch;

    localparam int N        = 8;
    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 64;
    localparam int STUB_LAT = N + 1;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] req_x = '0, req_y = '0;
    logic         div_start;
    logic [N-1:0] div_x, div_y;
    logic [N-1:0] div_quot = '0, div_rem = '0;
    logic         div_valid = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [N-1:0] res_quot, res_rem;
    logic         res_dbz, res_err, busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   start_cnt = 0;
    exp_t exp_q [$];
    exp_t mon_e;

    logic [N-1:0] stub_x = '0, stub_y = '0;
    int           stub_cnt = 0;
    logic         stub_hang = 1'b0;
    logic         hang_next = 1'b0;

    logic [N-1:0] b2b_x [4] = '{8'd9, 8'd255, 8'd3, 8'd0};
    logic [N-1:0] b2b_y [4] = '{8'd2, 8'd16,  8'd5, 8'd1};

    div_dispatch #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .div_start (div_start),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_quot  (div_quot),
        .div_rem   (div_rem),
        .div_valid (div_valid),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_quot  (res_quot),
        .res_rem   (res_rem),
        .res_dbz   (res_dbz),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: drops done on launch, raises it STUB_LAT cycles later (never, when hung).
    always @(posedge clk) begin
        if (div_start) begin
            stub_x    <= div_x;
            stub_y    <= div_y;
            stub_hang <= hang_next;
            stub_cnt  <= STUB_LAT;
            div_valid <= 1'b0;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else if (stub_cnt == 1) begin
            stub_cnt <= 0;
            if (!stub_hang) begin
                div_valid <= 1'b1;
                div_quot  <= stub_x / stub_y;
                div_rem   <= stub_x % stub_y;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_model(input logic [N-1:0] x, input logic [N-1:0] y, input bit hang);
        exp_t e;
        if (hang)         e = '{q: '0, r: '0, dbz: 1'b0, err: 1'b1};
        else if (y == 0)  e = '{q: {N{1'b1}}, r: x, dbz: 1'b1, err: 1'b0};
        else              e = '{q: x / y, r: x % y, dbz: 1'b0, err: 1'b0};
        return e;
    endfunction

    // Scoreboard monitor: every completed result handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (div_start) start_cnt <= start_cnt + 1;
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("res_spurious_valid", 32'(res_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_quot", 32'(res_quot), 32'(mon_e.q));
                check("res_rem",  32'(res_rem),  32'(mon_e.r));
                check("res_dbz",  32'(res_dbz),  32'(mon_e.dbz));
                check("res_err",  32'(res_err),  32'(mon_e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [N-1:0] x, input logic [N-1:0] y, input bit hang);
        int w = 0;
        req_x = x;
        req_y = y;
        req_valid = 1'b1;
        while (!req_ready && w < 300) begin
            tick();
            w++;
        end
        if (!req_ready) begin
            check("push_accept_timeout", 32'(req_ready), 32'd1);
        end else begin
            exp_q.push_back(ref_model(x, y, hang));
            if (hang) hang_next = 1'b1;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_res_valid(input string name);
        int w = 0;
        while (!res_valid && w < 300) begin
            tick();
            w++;
        end
        if (!res_valid) check(name, 32'(res_valid), 32'd1);
    endtask

    task automatic wait_start();
        int w = 0;
        while (!div_start && w < 50) begin
            tick();
            w++;
        end
        if (!div_start) check("wait_start_timeout", 32'(div_start), 32'd1);
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_q.size() != 0 || busy) && w < 3000) begin
            tick();
            w++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_div_start"}, 32'(div_start), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_div_x"},     32'(div_x),     32'd0);
        check({tag, "_div_y"},     32'(div_y),     32'd0);
        check({tag, "_res_quot"},  32'(res_quot),  32'd0);
        check({tag, "_res_rem"},   32'(res_rem),   32'd0);
        check({tag, "_res_dbz"},   32'(res_dbz),   32'd0);
        check({tag, "_res_err"},   32'(res_err),   32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int launch_cyc;
        int sent;
        int guard;
        bit saw_res, saw_start, saw_dv;

        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;

        // Single request: launch two cycles after acceptance, result one cycle after done edge.
        res_ready = 1'b1;
        push_req(8'd100, 8'd7, 1'b0);
        check("start_not_yet", 32'(div_start), 32'd0);
        tick();
        check("start_pulse", 32'(div_start), 32'd1);
        check("start_div_x", 32'(div_x), 32'd100);
        check("start_div_y", 32'(div_y), 32'd7);
        tick();
        check("start_one_cycle", 32'(div_start), 32'd0);
        s = 0;
        while (!div_valid && s < 50) begin
            tick();
            s++;
        end
        check("done_seen", 32'(div_valid), 32'd1);
        check("res_not_before_edge", 32'(res_valid), 32'd0);
        tick();
        check("res_after_edge", 32'(res_valid), 32'd1);
        wait_drain();

        // Divide-by-zero: answered locally two cycles after acceptance, no launch.
        s = start_cnt;
        push_req(8'd45, 8'd0, 1'b0);
        check("dbz_not_yet", 32'(res_valid), 32'd0);
        tick();
        check("dbz_res_valid", 32'(res_valid), 32'd1);
        check("dbz_flag", 32'(res_dbz), 32'd1);
        wait_drain();
        check("dbz_no_start", 32'(start_cnt), 32'(s));

        // Fill the queue behind a stalled result; the fifth push must be refused.
        res_ready = 1'b0;
        push_req(8'd200, 8'd10, 1'b0);
        wait_res_valid("blocker_res_timeout");
        for (int i = 0; i < 4; i++) begin
            req_x = b2b_x[i];
            req_y = b2b_y[i];
            req_valid = 1'b1;
            check("b2b_ready", 32'(req_ready), 32'd1);
            exp_q.push_back(ref_model(b2b_x[i], b2b_y[i], 1'b0));
            tick();
        end
        check("full_after4", 32'(req_ready), 32'd0);
        req_x = 8'd1;
        req_y = 8'd1;
        repeat (3) begin
            check("no_write_through", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        wait_drain();

        // Held result stays stable and blocks further launches until the handshake.
        res_ready = 1'b0;
        push_req(8'd50, 8'd6, 1'b0);
        wait_res_valid("hold_res_timeout");
        push_req(8'd77, 8'd3, 1'b0);
        s = start_cnt;
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_quot",  32'(res_quot),  32'd8);
            check("hold_rem",   32'(res_rem),   32'd2);
            tick();
        end
        check("hold_no_start", 32'(start_cnt), 32'(s));
        res_ready = 1'b1;
        wait_drain();
        check("hold_then_start", 32'(start_cnt), 32'(s + 1));

        // Hung divider: error response after the full wait window, next request proceeds.
        push_req(8'd120, 8'd11, 1'b1);
        wait_start();
        launch_cyc = cyc;
        tick();
        hang_next = 1'b0;
        push_req(8'd120, 8'd11, 1'b0);
        wait_res_valid("timeout_res_timeout");
        check("timeout_latency", 32'(cyc - launch_cyc), 32'(TIMEOUT + 1));
        check("timeout_err", 32'(res_err), 32'd1);
        wait_drain();

        // Reset in WAIT with two queued entries abandons everything.
        push_req(8'd200, 8'd3, 1'b0);
        wait_start();
        tick();
        push_req(8'd9, 8'd9, 1'b0);
        push_req(8'd8, 8'd1, 1'b0);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        tick();
        rst = 1'b0;
        saw_res = 1'b0;
        saw_start = 1'b0;
        saw_dv = 1'b0;
        repeat (30) begin
            tick();
            if (res_valid) saw_res = 1'b1;
            if (div_start) saw_start = 1'b1;
            if (div_valid) saw_dv = 1'b1;
        end
        check("late_done_seen", 32'(saw_dv), 32'd1);
        check("post_reset_no_res", 32'(saw_res), 32'd0);
        check("post_reset_no_start", 32'(saw_start), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Randomized traffic with random downstream backpressure.
        sent = 0;
        guard = 0;
        while (sent < 40 && guard < 4000) begin
            res_ready = 1'($urandom_range(0, 1));
            if (!req_valid && $urandom_range(0, 3) != 0) begin
                req_x = 8'($urandom);
                req_y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                req_valid = 1'b1;
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(ref_model(req_x, req_y, 1'b0));
                sent++;
                tick();
                req_valid = 1'b0;
            end else begin
                tick();
            end
            guard++;
        end
        req_valid = 1'b0;
        check("random_sent", 32'(sent), 32'd40);
        res_ready = 1'b1;
        wait_drain();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
